// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and baud constants.
// The transmitter stage uses the same package.
package uart_pkg;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 19200;
    localparam int BAUD_DIV  = 163;

    localparam int DEF_NB_DATA      = 8;
    localparam int DEF_OVERSAMPLING = 16;
    localparam int DEF_SB_TICK      = 16;
    localparam int DEF_NB_TICK_CNT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// The reset value is a parameter so that idle-high lines come out of reset idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver driven by a 16x oversampling tick.
// Delivers each byte with a one-clock done strobe and a framing-error flag.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int NB_DATA      = DEF_NB_DATA,
    parameter int OVERSAMPLING = DEF_OVERSAMPLING,
    parameter int SB_TICK      = DEF_SB_TICK,
    parameter int NB_TICK_CNT  = DEF_NB_TICK_CNT
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    localparam int NB_N = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [NB_TICK_CNT-1:0] START_LAST = NB_TICK_CNT'(OVERSAMPLING / 2 - 1);
    localparam logic [NB_TICK_CNT-1:0] DATA_LAST  = NB_TICK_CNT'(OVERSAMPLING - 1);
    localparam logic [NB_TICK_CNT-1:0] STOP_LAST  = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_N-1:0]        N_LAST     = NB_N'(NB_DATA - 1);

    logic                   rx_s;
    logic                   rx_prev_q, rx_prev_d;
    logic                   falling_edge;
    uart_state_e            state_q, state_d;
    logic [NB_TICK_CNT-1:0] s_cnt_q, s_cnt_d;
    logic [NB_N-1:0]        n_cnt_q, n_cnt_d;
    logic [NB_DATA-1:0]     shreg_q, shreg_d;
    logic [NB_DATA-1:0]     data_q, data_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk  (clk),
        .i_rst(i_rst),
        .i_d  (i_rx),
        .o_q  (rx_s)
    );

    // A start needs a genuine 1->0 transition, so a held-low break cannot retrigger.
    assign falling_edge = rx_prev_q & ~rx_s;

    always_comb begin
        rx_prev_d = rx_s;
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        n_cnt_d   = n_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        ferr_d    = ferr_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (falling_edge) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_cnt_q == START_LAST) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_cnt_q == DATA_LAST) begin
                        shreg_d = {rx_s, shreg_q[NB_DATA-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        data_d  = shreg_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            n_cnt_q   <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            n_cnt_q   <= n_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: serial frames are driven on i_rx and every received byte,
// its framing flag and the exact cycle of its done strobe are compared against expectations.
module tb_uart_rx_core;

    localparam int TICK_DIV      = 5;
    localparam int OS            = 16;
    localparam int NB            = 8;
    localparam int SB            = 16;
    localparam int BIT_CLK       = OS * TICK_DIV;
    localparam int TICKS_TO_DONE = OS / 2 + NB * OS + SB;
    localparam int EDGE_LAT      = 3;
    localparam int HIST_LEN      = 65536;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         p0;
    } exp_t;

    logic       clk;
    logic       i_rst;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;

    int   total_checks = 0;
    int   bad_checks   = 0;
    int   cyc          = 0;
    int   pulses       = 0;
    int   last_done    = 0;
    int   prev_done    = 0;
    bit   started      = 0;
    bit   tick_hist [0:HIST_LEN-1];
    exp_t exp_q [$];

    logic [7:0] model_data = 8'h00;
    logic       model_ferr = 1'b0;

    uart_rx_core dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_tick     (i_tick),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge index and a record of which edges carried a tick.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < HIST_LEN) tick_hist[cyc] = i_tick;
    end

    task automatic waitClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total_checks++;
        if (act !== req) begin
            bad_checks++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // The done strobe belongs on the edge carrying the last tick of the frame, counting
    // ticks from the edge after the start edge has crossed the synchroniser and edge flop.
    function automatic int expectedDone(input int p0, input int upto);
        int n = 0;
        for (int c = p0 + EDGE_LAT + 1; c <= upto && c < HIST_LEN; c++) begin
            if (tick_hist[c]) begin
                n++;
                if (n == TICKS_TO_DONE) return c;
            end
        end
        return -1;
    endfunction

    // Sends one 8N1 frame from the current posedge+1 alignment.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input bit expect_rx);
        exp_t e;
        if (expect_rx) begin
            e.data = b;
            e.ferr = ~stop_bit;
            e.p0   = cyc;
            exp_q.push_back(e);
        end
        i_rx = 1'b0;
        waitClk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            waitClk(BIT_CLK);
        end
        i_rx = stop_bit;
        waitClk(BIT_CLK);
    endtask

    initial begin
        i_tick = 1'b0;
        forever begin
            waitClk(TICK_DIV - 1);
            i_tick = 1'b1;
            waitClk(1);
            i_tick = 1'b0;
        end
    end

    // Every cycle: outputs must hold the last delivered frame; each strobe must match the oldest frame.
    always @(negedge clk) begin
        if (started) begin
            if (o_rx_done) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    model_data = e.data;
                    model_ferr = e.ferr;
                    checkOutput("done_cycle", cyc, expectedDone(e.p0, cyc));
                    prev_done = last_done;
                    last_done = cyc;
                end
            end
            checkOutput("o_data_hold", {24'd0, o_data}, {24'd0, model_data});
            checkOutput("o_frame_err_hold", {31'd0, o_frame_err}, {31'd0, model_ferr});
            if (i_rst) begin
                model_data = 8'h00;
                model_ferr = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       stop_bit;
        logic [7:0] pattern;
        int         budget;
        logic [7:0] partial;

        i_rst = 1'b1;
        i_rx  = 1'b1;
        waitClk(3);
        i_rst = 1'b0;
        waitClk(1);
        started = 1;

        checkOutput("reset_o_data", {24'd0, o_data}, 32'h0);
        checkOutput("reset_o_rx_done", {31'd0, o_rx_done}, 32'h0);
        checkOutput("reset_o_frame_err", {31'd0, o_frame_err}, 32'h0);

        waitClk(10 * BIT_CLK);
        checkOutput("idle_pulses", pulses, 0);
        checkOutput("idle_o_data", {24'd0, o_data}, 32'h0);

        // Bits 1,1,1,0,0,0,1,0 in line order, LSB first.
        pattern = 8'b0100_0111;
        applyStimulus(pattern, 1'b1, 1'b1);
        waitClk(BIT_CLK);
        checkOutput("frame47_pulses", pulses, 1);
        checkOutput("frame47_data", {24'd0, o_data}, 32'h47);
        checkOutput("frame47_ferr", {31'd0, o_frame_err}, 32'h0);

        applyStimulus(8'h55, 1'b1, 1'b1);
        checkOutput("b2b_first_data", {24'd0, o_data}, 32'h55);
        applyStimulus(8'hAA, 1'b1, 1'b1);
        waitClk(BIT_CLK);
        checkOutput("b2b_pulses", pulses, 3);
        checkOutput("b2b_second_data", {24'd0, o_data}, 32'hAA);
        checkOutput("b2b_gap_10_bits", {31'd0, (last_done - prev_done >= 10 * BIT_CLK - TICK_DIV * 2)
                                              && (last_done - prev_done <= 10 * BIT_CLK + TICK_DIV * 2)}, 32'h1);

        i_rx = 1'b0;
        waitClk(4 * TICK_DIV);
        i_rx = 1'b1;
        waitClk(2 * BIT_CLK);
        checkOutput("glitch_pulses", pulses, 3);
        applyStimulus(8'h3C, 1'b1, 1'b1);
        waitClk(BIT_CLK);
        checkOutput("after_glitch_pulses", pulses, 4);
        checkOutput("after_glitch_data", {24'd0, o_data}, 32'h3C);

        applyStimulus(8'hF0, 1'b0, 1'b1);
        waitClk(3 * BIT_CLK);
        checkOutput("break_pulses", pulses, 5);
        checkOutput("break_data", {24'd0, o_data}, 32'hF0);
        checkOutput("break_ferr", {31'd0, o_frame_err}, 32'h1);
        i_rx = 1'b1;
        waitClk(2 * BIT_CLK);

        // Start bit plus four data bits, then a one-clock reset with the line released.
        partial = 8'h5A;
        i_rx = 1'b0;
        waitClk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            i_rx = partial[i];
            waitClk(BIT_CLK);
        end
        i_rst = 1'b1;
        i_rx  = 1'b1;
        waitClk(1);
        i_rst = 1'b0;
        waitClk(1);
        checkOutput("midreset_o_data", {24'd0, o_data}, 32'h0);
        checkOutput("midreset_o_frame_err", {31'd0, o_frame_err}, 32'h0);
        checkOutput("midreset_o_rx_done", {31'd0, o_rx_done}, 32'h0);
        waitClk(12 * BIT_CLK);
        checkOutput("midreset_pulses", pulses, 5);
        applyStimulus(8'h81, 1'b1, 1'b1);
        waitClk(BIT_CLK);
        checkOutput("after_reset_data", {24'd0, o_data}, 32'h81);
        checkOutput("after_reset_ferr", {31'd0, o_frame_err}, 32'h0);

        for (int k = 0; k < 12; k++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            waitClk($urandom_range(0, 7));
            applyStimulus(b, stop_bit, 1'b1);
            if (!stop_bit) begin
                i_rx = 1'b1;
                waitClk(BIT_CLK);
            end else begin
                waitClk($urandom_range(0, 1) * BIT_CLK);
            end
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            waitClk(1);
            budget++;
        end
        checkOutput("all_frames_delivered", exp_q.size(), 0);
        checkOutput("total_pulses", pulses, 18);
        waitClk(2);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receiver stage that sits directly behind the i_rx pin inside top. It deserialises 8N1 frames using the shared 16x oversampling tick from the baud generator. Each received byte is handed to the downstream interface/ALU controller as a parallel word with a one-cycle done strobe and a framing-error flag.

Parameters:
NB_DATA, 8, data bits per frame (LSB transmitted first)
OVERSAMPLING, 16, ticks per bit period
SB_TICK, 16, ticks spanned by the stop bit (16 = 1 stop bit)
NB_TICK_CNT, 4, width of the tick counter; must satisfy 2^NB_TICK_CNT >= max(OVERSAMPLING, SB_TICK)

Ports:
clk  input  1  system clock (50 MHz in top)
i_rst  input  1  synchronous, active-high reset
i_tick  input  1  oversampling strobe, one clk wide, period = clk/(BAUD*16); 163 clk at 50 MHz/19200
i_rx  input  1  asynchronous serial line, idle high
o_data  output  NB_DATA  last received byte, held until the next completed frame
o_rx_done  output  1  one-clk pulse when o_data updates
o_frame_err  output  1  stop bit sampled low on the last frame; held until the next completed frame

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (i_rst). All flops update on the rising edge of clk.
- Reset values: o_data=0, o_rx_done=0, o_frame_err=0, state=IDLE, counters=0, shift register=0. Synchroniser flops reset to 1 (line idle).
- i_rx passes through a 2-FF synchroniser, then one extra flop for edge detection. Internal rx_s is the synchronised value.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: detect a falling edge of rx_s (previous 1, current 0), independent of i_tick. On detection: go to START and clear s_cnt. A line held low, such as a break, never re-triggers without first returning high.
- START: on each i_tick, increment s_cnt. When s_cnt==OVERSAMPLING/2-1 (7) on a tick:
  - rx_s==0: go to DATA and clear s_cnt and n_cnt.
  - rx_s==1: glitch; return to IDLE with no output activity.
- DATA: on each i_tick, increment s_cnt. When s_cnt==OVERSAMPLING-1 on a tick:
  - Sample at mid-bit: shreg <= {rx_s, shreg[NB_DATA-1:1]}. The first received bit lands in the LSB.
  - Clear s_cnt.
  - If n_cnt==NB_DATA-1, go to STOP; otherwise increment n_cnt.
- STOP: on each i_tick, increment s_cnt. When s_cnt==SB_TICK-1 on a tick:
  - o_data <= shreg, o_frame_err <= ~rx_s, o_rx_done <= 1 for exactly one clk.
  - Go to IDLE.
- Latency: o_rx_done rises one clk after the stop-sampling tick edge. That is about 9.5 bit periods after the start-bit falling edge, plus 2-3 clk of synchroniser delay.
- Ticks arriving in IDLE are ignored. A falling edge arriving in START/DATA/STOP is ignored; only ticks advance those states.
- A framing error still delivers data and pulses o_rx_done, and the FSM returns to IDLE. Upstream logic decides whether to discard the byte.
- i_rst asserted mid-frame: all state returns to reset values on the next edge. A partial frame is discarded with no done pulse.
- Counter widths: s_cnt is NB_TICK_CNT bits and is never allowed to wrap past its terminal value. n_cnt is $clog2(NB_DATA) bits.
- No back-pressure: the consumer must latch o_data within one frame time (about 10 bit periods).

Decomposition:
- Shared package uart_pkg: FSM state encoding (2-bit localparams IDLE/START/DATA/STOP), default NB_DATA, OVERSAMPLING, SB_TICK, and the baud/clock constants (CLK_FREQ=50_000_000, BAUD_RATE=19200, BAUD_DIV=163).
- The uart_tx stage reuses the same package.
- One natural sub-module: sync_2ff (parameterised reset value, 1-bit), instantiated for i_rx.

Test Plan:
- Reset, then idle line high for 10 bit times -> o_rx_done never pulses; o_data=0x00, o_frame_err=0.
- Frame with start bit, then bits 1,1,1,0,0,0,1,0 in transmission order, then stop=1 -> single o_rx_done pulse; o_data=0x47, o_frame_err=0.
- Back-to-back frames 0x55 then 0xAA with no idle gap -> two pulses about 10 bit periods apart; o_data=0x55, then 0xAA.
- Start-bit glitch: i_rx low for 4 ticks, then high -> no pulse; FSM back in IDLE. A following valid 0x3C frame is received correctly.
- Stop bit driven low (frame 0xF0 with stop=0) -> o_rx_done pulses; o_data=0xF0, o_frame_err=1. The line stays low and there is no second pulse until it returns high and a new start bit arrives.
- i_rst asserted for 1 clk after the 4th data bit of a frame -> no pulse, all outputs 0. The next full frame 0x81 gives o_data=0x81.
